// File: rtl/audio_gain_ctrl.sv
// Button-stepped 3-bit gain stage with 24-bit saturation for the stereo path.
// Optional clip indicator with hold-off is built when AUDIO_GAIN_CLIP_EN is defined.
module audio_gain_ctrl #(
  parameter int         DEBOUNCE_CYCLES  = 1_000_000,
  parameter logic [2:0] GAIN_RESET       = 3'd1,
  parameter int         CLIP_HOLD_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        sample_valid,
  input  logic [23:0] ldata_in,
  input  logic [23:0] rdata_in,
  output logic [23:0] ldata_out,
  output logic [23:0] rdata_out,
  output logic        out_valid,
  output logic [2:0]  gain,
  output logic        clip
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || CLIP_HOLD_CYCLES < 1) begin : g_bad_param
    $error("audio_gain_ctrl: DEBOUNCE_CYCLES must be >= 2 and CLIP_HOLD_CYCLES >= 1");
  end

  logic [1:0]      up_sync, dn_sync;
  logic [DB_W-1:0] up_cnt, dn_cnt;
  logic            up_acc, dn_acc, up_acc_d, dn_acc_d;
  logic            up_step, dn_step;

  // up_sync[1] / dn_sync[1] are the synchronised button levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_dn};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_cnt <= '0;
      up_acc <= 1'b0;
    end else if (up_sync[1] == up_acc) begin
      up_cnt <= '0;
    end else if (up_cnt == DB_LAST) begin
      up_cnt <= '0;
      up_acc <= ~up_acc;
    end else begin
      up_cnt <= up_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_cnt <= '0;
      dn_acc <= 1'b0;
    end else if (dn_sync[1] == dn_acc) begin
      dn_cnt <= '0;
    end else if (dn_cnt == DB_LAST) begin
      dn_cnt <= '0;
      dn_acc <= ~dn_acc;
    end else begin
      dn_cnt <= dn_cnt + 1'b1;
    end
  end

  assign up_step = up_acc & ~up_acc_d;
  assign dn_step = dn_acc & ~dn_acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_acc_d <= 1'b0;
      dn_acc_d <= 1'b0;
      gain     <= GAIN_RESET;
    end else begin
      up_acc_d <= up_acc;
      dn_acc_d <= dn_acc;
      if (up_step && !dn_step && gain != 3'd7)
        gain <= gain + 3'd1;
      else if (dn_step && !up_step && gain != 3'd0)
        gain <= gain - 3'd1;
    end
  end

  function automatic logic [23:0] sat24(input logic signed [26:0] p);
    if (p > 27'sd8388607)       return 24'h7FFFFF;
    else if (p < -27'sd8388608) return 24'h800000;
    else                        return p[23:0];
  endfunction

  // Gain is sampled in the same S1 register that holds both products, so a pair never splits
  logic signed [26:0] l_prod_c, r_prod_c, l_prod, r_prod;
  logic               s1_valid;

  assign l_prod_c = $signed({{3{ldata_in[23]}}, ldata_in}) * $signed({24'd0, gain});
  assign r_prod_c = $signed({{3{rdata_in[23]}}, rdata_in}) * $signed({24'd0, gain});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      l_prod   <= '0;
      r_prod   <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        l_prod <= l_prod_c;
        r_prod <= r_prod_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ldata_out <= '0;
      rdata_out <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ldata_out <= sat24(l_prod);
        rdata_out <= sat24(r_prod);
      end
    end
  end

`ifdef AUDIO_GAIN_CLIP_EN
  localparam int CL_W = $clog2(CLIP_HOLD_CYCLES + 1);
  logic [CL_W-1:0] clip_cnt;
  logic            sat_any;

  assign sat_any = (l_prod > 27'sd8388607) || (l_prod < -27'sd8388608) ||
                   (r_prod > 27'sd8388607) || (r_prod < -27'sd8388608);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
      clip     <= 1'b0;
    end else if (s1_valid && sat_any) begin
      clip_cnt <= CL_W'(CLIP_HOLD_CYCLES);
      clip     <= 1'b1;
    end else if (clip_cnt != '0) begin
      clip_cnt <= clip_cnt - 1'b1;
      clip     <= (clip_cnt != CL_W'(1));
    end else begin
      clip     <= 1'b0;
    end
  end
`else
  assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_audio_gain_ctrl.sv
// Directed bench for audio_gain_ctrl: debounce, gain stepping, saturation, pipeline, reset.
module tb_audio_gain_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_dn = 1'b0, sample_valid = 1'b0;
  logic [23:0] ldata_in = '0, rdata_in = '0;
  logic [23:0] ldata_out, rdata_out;
  logic        out_valid, clip;
  logic [2:0]  gain;
  int checks = 0;
  int failures = 0;

`ifdef AUDIO_GAIN_CLIP_EN
  localparam logic CLIP_EXP = 1'b1;
`else
  localparam logic CLIP_EXP = 1'b0;
`endif

  audio_gain_ctrl #(.DEBOUNCE_CYCLES(4), .GAIN_RESET(3'd1), .CLIP_HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .sample_valid(sample_valid), .ldata_in(ldata_in), .rdata_in(rdata_in),
    .ldata_out(ldata_out), .rdata_out(rdata_out), .out_valid(out_valid),
    .gain(gain), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic press(input logic up, input logic dn, input int hold);
    btn_up = up; btn_dn = dn;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Drives one sample and checks its result two cycles later
  task automatic sample_check(input string name, input logic [23:0] l, input logic [23:0] r,
                              input logic [23:0] el, input logic [23:0] er);
    sample_valid = 1'b1; ldata_in = l; rdata_in = r;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s early_valid got=%b exp=0", name, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s valid got=%b exp=1", name, out_valid); end
    checks++; if (ldata_out !== el) begin failures++; $display("FAIL %s ldata got=%h exp=%h", name, ldata_out, el); end
    checks++; if (rdata_out !== er) begin failures++; $display("FAIL %s rdata got=%h exp=%h", name, rdata_out, er); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (gain !== 3'd1) begin failures++; $display("FAIL reset_gain got=%0d exp=1", gain); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (ldata_out !== 24'h0 || rdata_out !== 24'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", ldata_out, rdata_out); end
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL reset_clip got=%b exp=0", clip); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_passthrough;
    sample_check("pass", 24'h000100, 24'hFFFF00, 24'h000100, 24'hFFFF00);
    checks++; if (gain !== 3'd1) begin failures++; $display("FAIL pass_gain got=%0d exp=1", gain); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pass_pulse got=%b exp=0", out_valid); end
    checks++; if (ldata_out !== 24'h000100) begin failures++; $display("FAIL pass_hold got=%h exp=000100", ldata_out); end
  endtask

  task automatic test_debounce;
    press(1'b1, 1'b0, 3);
    checks++; if (gain !== 3'd1) begin failures++; $display("FAIL short_press got=%0d exp=1", gain); end
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (gain !== 3'd1) begin failures++; $display("FAIL step_early got=%0d exp=1", gain); end
    @(negedge clk);
    checks++; if (gain !== 3'd2) begin failures++; $display("FAIL step_latency got=%0d exp=2", gain); end
    press(1'b1, 1'b0, 13);
    checks++; if (gain !== 3'd2) begin failures++; $display("FAIL held_once got=%0d exp=2", gain); end
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 20);
    checks++; if (gain !== 3'd7) begin failures++; $display("FAIL up_to_7 got=%0d exp=7", gain); end
    press(1'b1, 1'b0, 20);
    checks++; if (gain !== 3'd7) begin failures++; $display("FAIL sat_7 got=%0d exp=7", gain); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 20);
    checks++; if (gain !== 3'd4) begin failures++; $display("FAIL down_to_4 got=%0d exp=4", gain); end
    sample_check("sat", 24'h300000, 24'hD00000, 24'h7FFFFF, 24'h800000);
    checks++; if (clip !== CLIP_EXP) begin failures++; $display("FAIL clip_set got=%b exp=%b", clip, CLIP_EXP); end
    repeat (12) @(negedge clk);
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL clip_release got=%b exp=0", clip); end
    sample_check("nosat", 24'h1FFFFF, 24'hF00000, 24'h7FFFFC, 24'hC00000);
    checks++; if (clip !== 1'b0) begin failures++; $display("FAIL clip_nosat got=%b exp=0", clip); end
  endtask

  task automatic test_mute;
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 20);
    checks++; if (gain !== 3'd0) begin failures++; $display("FAIL down_to_0 got=%0d exp=0", gain); end
    sample_check("mute", 24'h123456, 24'hFEDCBA, 24'h000000, 24'h000000);
    press(1'b1, 1'b1, 20);
    checks++; if (gain !== 3'd0) begin failures++; $display("FAIL simultaneous got=%0d exp=0", gain); end
  endtask

  task automatic test_back_to_back;
    press(1'b1, 1'b0, 20);
    press(1'b1, 1'b0, 20);
    checks++; if (gain !== 3'd2) begin failures++; $display("FAIL b2b_start got=%0d exp=2", gain); end
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    sample_valid = 1'b1; ldata_in = 24'h000010; rdata_in = 24'h000010;
    @(negedge clk);
    checks++; if (gain !== 3'd3) begin failures++; $display("FAIL b2b_step got=%0d exp=3", gain); end
    ldata_in = 24'h000010; rdata_in = 24'hFFFFF0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ldata_out !== 24'h000020 || rdata_out !== 24'h000020) begin
      failures++; $display("FAIL b2b_first got=%b %h %h exp=1 000020 000020", out_valid, ldata_out, rdata_out); end
    ldata_in = 24'hFFFFF0; rdata_in = 24'h000001;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || ldata_out !== 24'h000030 || rdata_out !== 24'hFFFFD0) begin
      failures++; $display("FAIL b2b_second got=%b %h %h exp=1 000030 ffffd0", out_valid, ldata_out, rdata_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ldata_out !== 24'hFFFFD0 || rdata_out !== 24'h000003) begin
      failures++; $display("FAIL b2b_third got=%b %h %h exp=1 ffffd0 000003", out_valid, ldata_out, rdata_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    sample_valid = 1'b1; ldata_in = 24'h000100; rdata_in = 24'h000200;
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0 || ldata_out !== 24'h0 || rdata_out !== 24'h0 || clip !== 1'b0) begin
        failures++; $display("FAIL rst_outputs got=%b %h %h %b exp=0 0 0 0", out_valid, ldata_out, rdata_out, clip); end
      checks++; if (gain !== 3'd1) begin failures++; $display("FAIL rst_gain got=%0d exp=1", gain); end
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_discard got=%b exp=0", out_valid); end
    end
    sample_check("post_rst", 24'h000100, 24'h000200, 24'h000100, 24'h000200);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_debounce();
    test_saturation();
    test_mute();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_gain_ctrl.md
# audio_gain_ctrl

Button-controlled digital gain stage between the per-channel FIR low-pass filters and the I2S transmitter. It replaces the constant gain currently driven to the 7-segment display. Two raw push-buttons are debounced and step a 3-bit gain value. Each stereo sample pair is multiplied by that gain and saturated to 24-bit signed before it is handed to the transmitter.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable `clk` cycles before a button level is accepted (10 ms at 100 MHz).
- GAIN_RESET, 3'd1: gain value loaded on reset.
- CLIP_HOLD_CYCLES, 10_000_000: clip indicator stretch length (macro build only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_up  in  1  raw gain-up button, asynchronous to clk.
- btn_dn  in  1  raw gain-down button, asynchronous to clk.
- sample_valid  in  1  single-cycle pulse; ldata_in/rdata_in valid this cycle. Already synchronised to clk by the caller.
- ldata_in  in  24  left sample, two's complement.
- rdata_in  in  24  right sample, two's complement.
- ldata_out  out  24  left sample after gain and saturation.
- rdata_out  out  24  right sample after gain and saturation.
- out_valid  out  1  single-cycle pulse; outputs updated this cycle.
- gain  out  3  current gain, 0..7, for the display.
- clip  out  1  clip indicator; tied 0 without AUDIO_GAIN_CLIP_EN.

## Operation
- Synchronisers:
  - btn_up and btn_dn each pass through a 2-FF synchroniser.
- Debouncers (one per button):
  - A counter increments while the synchronised level differs from the accepted level.
  - The counter clears when the two levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level toggles and the counter clears.
- Step events:
  - A rising edge of an accepted level is one step event.
  - A held button produces exactly one step; there is no auto-repeat.
- Gain register:
  - Up step: gain+1, saturating at 7.
  - Down step: gain-1, saturating at 0.
  - Up and down step in the same cycle: no change.
- Sample gain:
  - The gain used for arithmetic is captured into sample_gain on each sample_valid.
  - Both channels of one pair always use the same gain.
  - A step arriving mid-pipeline affects only the next pair.
- Arithmetic, per channel:
  - product = signed(data_in) * unsigned(sample_gain), computed at 27-bit signed.
  - If product > 8388607, output 24'h7FFFFF.
  - If product < -8388608, output 24'h800000.
  - Otherwise output product[23:0].
  - Gain 0 mutes the channel (output 0). Gain 1 passes the sample bit-exact.
- Pipeline: two register stages.
  - S1: data and gain captured, product registered.
  - S2: saturation result registered, out_valid asserted.
- Back-to-back sample_valid on consecutive cycles is accepted at full rate. There is no stall and no backpressure.

## Timing
- Reset values:
  - gain = GAIN_RESET.
  - ldata_out = rdata_out = 0, out_valid = 0, clip = 0.
  - Debounce counters = 0, accepted levels = 0, pipeline valid bits = 0.
- Latency: out_valid is high exactly 2 clk cycles after the sample_valid cycle. Outputs hold until the next out_valid.
- Gain latency:
  - A button edge appears on `gain` 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
  - A button stable for fewer than DEBOUNCE_CYCLES cycles produces no step.
- Reset mid-operation: in-flight samples are discarded and no out_valid is produced. The first valid output after reset comes from a sample_valid at least one cycle after rst deasserts.

## Configuration
- AUDIO_GAIN_CLIP_EN defined:
  - clip goes high in the S2 cycle in which either channel saturated.
  - A hold counter reloads CLIP_HOLD_CYCLES on every saturation.
  - clip stays high until the counter reaches 0.
- AUDIO_GAIN_CLIP_EN undefined:
  - No hold counter or saturation-detect register is built.
  - clip is constant 0.
  - Saturation arithmetic is unchanged.

## Test plan
- Reset, then sample_valid with L=24'h000100, R=24'hFFFF00 -> 2 cycles later out_valid=1, L=24'h000100, R=24'hFFFF00, gain=1.
- DEBOUNCE_CYCLES=4; btn_up high for 3 cycles then low -> gain stays 1. btn_up high for 20 cycles -> gain=2 exactly once. Six more presses -> gain=7. A further press -> gain stays 7.
- gain=4, L=24'h300000, R=24'hD00000 -> L=24'h7FFFFF, R=24'h800000. clip=1 with macro, 0 without.
- gain=0 via down presses, L=24'h123456 -> L=0. Simultaneous up and down rising edges -> gain unchanged.
- sample_valid on 3 consecutive cycles, with a gain step landing between the 1st and 2nd -> 3 out_valid pulses on consecutive cycles. 1st output uses the old gain; 2nd and 3rd use the new gain.
- rst asserted one cycle after sample_valid -> no out_valid. All outputs 0 and gain=GAIN_RESET while rst is high.
